// File: rtl/dmem_wait_responder.sv
// Data-memory responder with req/ack handshake and a fixed number of
// wait states; serves one latched request at a time.
module dmem_wait_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_write,
   output logic [31:0] data_read,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam int unsigned IW = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || DEPTH > 65536) begin : g_bad_depth
         $fatal(1, "dmem_wait_responder: DEPTH out of range");
      end
      if (LATENCY > 15) begin : g_bad_latency
         $fatal(1, "dmem_wait_responder: LATENCY out of range");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   logic [31:0] mem [DEPTH];
   logic [IW-1:0] idx;
   logic        fault;
   logic        mem_we;

   assign idx = addr_q[IW+1:2];

   // Upper word-index bits beyond the array count as out of range.
   assign fault = (addr_q[1:0] != 2'b00) ||
                  ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      mem_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (req) begin
               addr_d  = data_addr;
               wdata_d = data_write;
               we_d    = we;
               cnt_d   = 4'(LATENCY);
               state_d = S_WAIT;
               busy_d  = 1'b1;
            end
         end
         S_WAIT: begin
            busy_d = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_RESP;
               ack_d   = 1'b1;
               if (fault) begin
                  err_d = 1'b1;
               end else if (we_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem[idx];
               end
            end
         end
         S_RESP: begin
            // Always return to IDLE; a held req is only seen there.
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge CLK) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
   end

   // A reset on the access edge abandons the store.
   always_ff @(posedge CLK) begin
      if (rst_n && mem_we) begin
         mem[idx] <= wdata_q;
      end
   end

   assign data_read = rdata_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench: LATENCY=2 instance for access/fault/reset tests,
// LATENCY=0 instance for back-to-back spacing.
module tb_dmem_wait_responder;

   logic        clk;
   logic        rst_n;

   logic        req2, we2;
   logic [31:0] addr2, wd2, rd2;
   logic        ack2, err2, busy2;

   logic        req0, we0;
   logic [31:0] addr0, wd0, rd0;
   logic        ack0, err0, busy0;

   int checks;
   int errors;

   dmem_wait_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
      .CLK        (clk),
      .rst_n      (rst_n),
      .req        (req2),
      .we         (we2),
      .data_addr  (addr2),
      .data_write (wd2),
      .data_read  (rd2),
      .ack        (ack2),
      .err        (err2),
      .busy       (busy2)
   );

   dmem_wait_responder #(.DEPTH(256), .LATENCY(0)) u_l0 (
      .CLK        (clk),
      .rst_n      (rst_n),
      .req        (req0),
      .we         (we0),
      .data_addr  (addr0),
      .data_write (wd0),
      .data_read  (rd0),
      .ack        (ack0),
      .err        (err0),
      .busy       (busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request on the LATENCY=2 instance, optionally
   // disturbing the inputs during WAIT, and returns what it saw.
   task automatic do_txn2(
      input  logic        w,
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  bit          perturb,
      output int          edges,
      output logic        bsy,
      output logic        got,
      output logic        e,
      output logic [31:0] rd
   );
      req2  = 1'b1;
      we2   = w;
      addr2 = a;
      wd2   = d;
      @(posedge clk);
      @(negedge clk);
      bsy   = busy2;
      edges = 0;
      if (perturb) begin
         addr2 = 32'h20;
         we2   = 1'b1;
         wd2   = 32'h55AA55AA;
      end
      while (!ack2 && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      got  = ack2;
      e    = err2;
      rd   = rd2;
      req2 = 1'b0;
      we2  = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({ack2, err2, busy2} !== 3'b000 || rd2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: ack/err/busy=%b rd=%h expected 000 rd=0",
                     i, {ack2, err2, busy2}, rd2);
         end
      end
   endtask

   task automatic test_store_load();
      int edges;
      logic bsy, got, e;
      logic [31:0] rd;
      do_txn2(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (bsy !== 1'b1) begin
         errors++;
         $display("FAIL store_busy: got %b expected 1", bsy);
      end
      checks++;
      if (got !== 1'b1 || edges != 3) begin
         errors++;
         $display("FAIL store_ack: ack=%b edges=%0d expected ack=1 edges=3", got, edges);
      end
      checks++;
      if (e !== 1'b0) begin
         errors++;
         $display("FAIL store_err: got %b expected 0", e);
      end
      do_txn2(1'b0, 32'h10, 32'h0, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || edges != 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL load_10: ack=%b edges=%0d err=%b rd=%h expected 1 3 0 deadbeef",
                  got, edges, e, rd);
      end
      checks++;
      if (busy2 !== 1'b0 || ack2 !== 1'b0) begin
         errors++;
         $display("FAIL idle_after: busy=%b ack=%b expected 0 0", busy2, ack2);
      end
   endtask

   task automatic test_faults();
      int edges;
      logic bsy, got, e;
      logic [31:0] rd;
      do_txn2(1'b1, 32'h13, 32'h12345678, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || e !== 1'b1) begin
         errors++;
         $display("FAIL misalign_store: ack=%b err=%b expected 1 1", got, e);
      end
      checks++;
      if (err2 !== 1'b0) begin
         errors++;
         $display("FAIL err_without_ack: got %b expected 0", err2);
      end
      do_txn2(1'b0, 32'h400, 32'h0, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || e !== 1'b1 || rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL range_load: ack=%b err=%b rd=%h expected 1 1 deadbeef", got, e, rd);
      end
      do_txn2(1'b0, 32'h80000010, 32'h0, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || e !== 1'b1) begin
         errors++;
         $display("FAIL upper_bits_load: ack=%b err=%b expected 1 1", got, e);
      end
      do_txn2(1'b0, 32'h10, 32'h0, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reread_10: ack=%b err=%b rd=%h expected 1 0 deadbeef", got, e, rd);
      end
   endtask

   task automatic test_wait_change();
      int edges;
      logic bsy, got, e;
      logic [31:0] rd;
      do_txn2(1'b1, 32'h20, 32'hA5A50020, 1'b0, edges, bsy, got, e, rd);
      do_txn2(1'b1, 32'h30, 32'h30303030, 1'b0, edges, bsy, got, e, rd);
      do_txn2(1'b0, 32'h30, 32'h0, 1'b1, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || e !== 1'b0 || rd !== 32'h30303030) begin
         errors++;
         $display("FAIL latched_load: ack=%b err=%b rd=%h expected 1 0 30303030", got, e, rd);
      end
      do_txn2(1'b0, 32'h20, 32'h0, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (rd !== 32'hA5A50020) begin
         errors++;
         $display("FAIL mem8_intact: got %h expected a5a50020", rd);
      end
   endtask

   task automatic test_reset_mid();
      int edges;
      int acks;
      logic bsy, got, e;
      logic [31:0] rd;
      do_txn2(1'b1, 32'h40, 32'h40400001, 1'b0, edges, bsy, got, e, rd);
      req2  = 1'b1;
      we2   = 1'b1;
      addr2 = 32'h40;
      wd2   = 32'hBAD0BAD0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      req2  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (busy2 !== 1'b0 || ack2 !== 1'b0 || rd2 !== 32'h0) begin
         errors++;
         $display("FAIL reset_wait: busy=%b ack=%b rd=%h expected 0 0 0", busy2, ack2, rd2);
      end
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack2 === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL reset_no_ack: got %0d acks expected 0", acks);
      end
      do_txn2(1'b0, 32'h40, 32'h0, 1'b0, edges, bsy, got, e, rd);
      checks++;
      if (got !== 1'b1 || rd !== 32'h40400001) begin
         errors++;
         $display("FAIL reset_store_dropped: ack=%b rd=%h expected 1 40400001", got, rd);
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      int first_ack;
      int second_ack;
      logic busy_e3;
      logic [31:0] rd_second;
      logic err_second;
      acks       = 0;
      first_ack  = -1;
      second_ack = -1;
      busy_e3    = 1'bx;
      rd_second  = 32'hx;
      err_second = 1'bx;
      req0  = 1'b1;
      we0   = 1'b1;
      addr0 = 32'h50;
      wd0   = 32'h11111111;
      for (int ed = 1; ed <= 12; ed++) begin
         @(posedge clk);
         @(negedge clk);
         if (ed == 3) busy_e3 = busy0;
         if (ack0 === 1'b1) begin
            acks++;
            if (acks == 1) begin
               first_ack = ed;
               we0 = 1'b0;
            end else if (acks == 2) begin
               second_ack = ed;
               rd_second  = rd0;
               err_second = err0;
            end
         end
      end
      req0 = 1'b0;
      checks++;
      if (acks != 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d acks expected 4", acks);
      end
      checks++;
      if (first_ack != 2 || second_ack != 5) begin
         errors++;
         $display("FAIL b2b_spacing: ack edges %0d,%0d expected 2,5", first_ack, second_ack);
      end
      checks++;
      if (busy_e3 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_resp_ignore: busy=%b expected 0", busy_e3);
      end
      checks++;
      if (rd_second !== 32'h11111111 || err_second !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load: rd=%h err=%b expected 11111111 0", rd_second, err_second);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req2   = 1'b0;
      we2    = 1'b0;
      addr2  = 32'h0;
      wd2    = 32'h0;
      req0   = 1'b0;
      we0    = 1'b0;
      addr0  = 32'h0;
      wd0    = 32'h0;
      test_reset();
      test_store_load();
      test_faults();
      test_wait_change();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
